// File: rtl/mvm4_part3.sv
// Streaming signed matrix-vector multiplier y = A*x.
// Operands are double buffered: the load bank fills while the compute bank
// feeds N multipliers one row per cycle, followed by a registered adder.
module mvm4_part3 #(
  parameter int MAT_SCALE    = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           done,
  input  logic signed [INPUT_WIDTH-1:0]  data_in,
  output logic signed [OUTPUT_WIDTH-1:0] data_out
);

  localparam int N     = MAT_SCALE;
  localparam int NA    = N * N;
  localparam int TOTAL = NA + N;
  localparam int WCW   = $clog2(TOTAL);
  localparam int OCW   = $clog2(N + 1);
  localparam int RW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {L_IDLE = 1'b0, L_LOAD = 1'b1} load_state_t;
  typedef enum logic [1:0] {O_IDLE = 2'b00, O_ARM = 2'b01, O_RUN = 2'b10} out_state_t;

  load_state_t r_lstate, w_lstate_nxt;
  logic [WCW-1:0] r_wcnt, w_wcnt_nxt;
  logic w_final;

  out_state_t r_ostate, w_ostate_nxt;
  logic [OCW-1:0] r_ocnt, w_ocnt_nxt;
  logic [RW-1:0] w_row;
  logic w_prod_en;
  logic w_out_en;
  logic w_done_nxt;

  // Load bank holds every word except the last, which goes straight to the compute bank.
  logic signed [INPUT_WIDTH-1:0]  r_ld   [TOTAL-1];
  logic signed [INPUT_WIDTH-1:0]  r_ca   [N][N];
  logic signed [INPUT_WIDTH-1:0]  r_cx   [N];
  logic signed [OUTPUT_WIDTH-1:0] r_prod [N];
  logic signed [OUTPUT_WIDTH-1:0] w_prod [N];
  logic signed [OUTPUT_WIDTH-1:0] w_sum;

  // Signed product, sign-extended (or wrapped) to the accumulator width.
  function automatic logic signed [OUTPUT_WIDTH-1:0] mul_ext(
    input logic signed [INPUT_WIDTH-1:0] a,
    input logic signed [INPUT_WIDTH-1:0] b
  );
    logic signed [2*INPUT_WIDTH-1:0] p;
    p = (2*INPUT_WIDTH)'(a) * (2*INPUT_WIDTH)'(b);
    return OUTPUT_WIDTH'(p);
  endfunction

  assign w_final = (r_lstate == L_LOAD) && (r_wcnt == WCW'(TOTAL - 1));

  // Load FSM next state: start is honoured in IDLE or alongside the final word.
  always_comb begin
    w_lstate_nxt = r_lstate;
    w_wcnt_nxt   = r_wcnt;
    case (r_lstate)
      L_IDLE: begin
        w_wcnt_nxt = '0;
        if (start) begin
          w_lstate_nxt = L_LOAD;
        end else begin
          w_lstate_nxt = L_IDLE;
        end
      end
      L_LOAD: begin
        if (w_final) begin
          w_wcnt_nxt = '0;
          if (start) begin
            w_lstate_nxt = L_LOAD;
          end else begin
            w_lstate_nxt = L_IDLE;
          end
        end else begin
          w_wcnt_nxt = r_wcnt + WCW'(1);
        end
      end
      default: begin
        w_lstate_nxt = L_IDLE;
        w_wcnt_nxt   = '0;
      end
    endcase
  end

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lstate <= L_IDLE;
      r_wcnt   <= '0;
    end else begin
      r_lstate <= w_lstate_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  // Capture operand words into the load bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TOTAL - 1; i++) r_ld[i] <= '0;
    end else if ((r_lstate == L_LOAD) && !w_final) begin
      r_ld[r_wcnt] <= data_in;
    end
  end

  // Hand the complete problem to the compute bank on the final word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) r_ca[r][c] <= '0;
        r_cx[r] <= '0;
      end
    end else if (w_final) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) r_ca[r][c] <= r_ld[r*N + c];
      end
      for (int k = 0; k < N - 1; k++) r_cx[k] <= r_ld[NA + k];
      r_cx[N-1] <= data_in;
    end
  end

  // Output FSM next state: ARM spends one cycle, RUN walks rows then drains the adder.
  always_comb begin
    w_ostate_nxt = r_ostate;
    w_ocnt_nxt   = r_ocnt;
    if (w_final) begin
      w_ostate_nxt = O_ARM;
      w_ocnt_nxt   = '0;
    end else begin
      case (r_ostate)
        O_IDLE: begin
          w_ostate_nxt = O_IDLE;
          w_ocnt_nxt   = '0;
        end
        O_ARM: begin
          w_ostate_nxt = O_RUN;
          w_ocnt_nxt   = '0;
        end
        O_RUN: begin
          if (r_ocnt == OCW'(N)) begin
            w_ostate_nxt = O_IDLE;
            w_ocnt_nxt   = '0;
          end else begin
            w_ocnt_nxt = r_ocnt + OCW'(1);
          end
        end
        default: begin
          w_ostate_nxt = O_IDLE;
          w_ocnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ostate <= O_IDLE;
      r_ocnt   <= '0;
    end else begin
      r_ostate <= w_ostate_nxt;
      r_ocnt   <= w_ocnt_nxt;
    end
  end

  // Pipeline controls: row c is multiplied at RUN step c and summed at step c+1.
  always_comb begin
    w_prod_en  = (r_ostate == O_RUN) && (r_ocnt < OCW'(N));
    w_out_en   = (r_ostate == O_RUN) && (r_ocnt != '0);
    w_done_nxt = (r_ostate == O_RUN) && (r_ocnt == '0);
    if (w_prod_en) begin
      w_row = RW'(r_ocnt);
    end else begin
      w_row = '0;
    end
  end

  // Row products and the modulo-2^OUTPUT_WIDTH adder tree.
  always_comb begin
    for (int k = 0; k < N; k++) w_prod[k] = mul_ext(r_ca[w_row][k], r_cx[k]);
    w_sum = '0;
    for (int k = 0; k < N; k++) w_sum = w_sum + r_prod[k];
  end

  // Registered products, done pulse and result word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) r_prod[k] <= '0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= w_done_nxt;
      if (w_prod_en) begin
        for (int k = 0; k < N; k++) r_prod[k] <= w_prod[k];
      end
      if (w_out_en) begin
        data_out <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_mvm4_part3.sv
// Self-checking bench for mvm4_part3: scoreboard of golden y values.
module tb_mvm4_part3;

  typedef logic signed [7:0]  word_t;
  typedef logic signed [15:0] res_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  start;
  logic  done;
  word_t data_in;
  res_t  data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  res_t  exp_q[$];
  word_t a_m[16];
  word_t x_v[4];

  mvm4_part3 #(.MAT_SCALE(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden model: full-precision sum, reduced modulo 2^16 at the end.
  task automatic push_golden();
    for (int j = 0; j < 4; j++) begin
      int s;
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(a_m[j*4 + k]) * int'(x_v[k]);
      exp_q.push_back(res_t'(s));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'sd0;
  endtask

  // Drive the 20 operand words; optionally raise start with the last one.
  task automatic send_words(input bit start_last);
    push_golden();
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      data_in = (w < 16) ? a_m[w] : x_v[w-16];
      start   = (w == 19) ? start_last : 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_in = 8'sd0;
    repeat (3) @(negedge clk);
    total++;
    if (done !== 1'b0 || data_out !== 16'sd0) begin
      bad++; $display("FAIL reset_state done=%b data_out=%0d want 0/0", done, data_out);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || data_out !== 16'sd0) begin
      bad++; $display("FAIL idle_after_reset done=%b data_out=%0d want 0/0", done, data_out);
    end
  endtask

  task automatic test_patterns();
    for (int p = 0; p < 4; p++) begin
      int   n;
      res_t e;
      res_t last_e;
      for (int i = 0; i < 16; i++) begin
        case (p)
          0: a_m[i] = (i % 5 == 0) ? 8'sd1 : 8'sd0;
          1: a_m[i] = 8'sd1;
          2: a_m[i] = -8'sd45;
          default: a_m[i] = 8'sd127;
        endcase
      end
      for (int k = 0; k < 4; k++) begin
        case (p)
          0: x_v[k] = word_t'(k + 1);
          1: x_v[k] = -8'sd1;
          2: x_v[k] = -8'sd45;
          default: x_v[k] = 8'sd127;
        endcase
      end
      pulse_start();
      send_words(1'b0);
      @(negedge clk); start = 1'b0; data_in = 8'sd0;
      n = 1;
      while (n < 30 && done !== 1'b1) begin
        @(negedge clk); n++;
      end
      total++;
      if (n !== 3) begin
        bad++; $display("FAIL pat%0d_done_latency got=%0d want=3", p, n);
      end
      last_e = 16'sd0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'sd0;
        last_e = e;
        total++;
        if (data_out !== e) begin
          bad++; $display("FAIL pat%0d_y%0d got=%0d want=%0d", p, j, data_out, e);
        end
        total++;
        if (done !== 1'b0) begin
          bad++; $display("FAIL pat%0d_done_width got=%b want=0", p, done);
        end
      end
      @(negedge clk);
      total++;
      if (data_out !== last_e || done !== 1'b0) begin
        bad++; $display("FAIL pat%0d_hold got=%0d/%b want=%0d/0", p, data_out, done, last_e);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int   n;
    int   extra;
    res_t e;
    pulse_start();
    for (int w = 0; w < 10; w++) begin
      @(negedge clk); start = 1'b0; data_in = word_t'(w + 3);
    end
    @(negedge clk); reset = 1'b1; start = 1'b0;
    @(negedge clk); reset = 1'b0;
    total++;
    if (done !== 1'b0 || data_out !== 16'sd0) begin
      bad++; $display("FAIL midreset_clear done=%b data_out=%0d want 0/0", done, data_out);
    end
    for (int i = 0; i < 16; i++) a_m[i] = (i % 5 == 0) ? 8'sd1 : 8'sd0;
    for (int k = 0; k < 4; k++) x_v[k] = word_t'(k + 5);
    pulse_start();
    send_words(1'b0);
    @(negedge clk); start = 1'b0; data_in = 8'sd0;
    n = 1;
    while (n < 30 && done !== 1'b1) begin
      @(negedge clk); n++;
    end
    total++;
    if (n !== 3) begin
      bad++; $display("FAIL midreset_done_latency got=%0d want=3", n);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'sd0;
      total++;
      if (data_out !== e || e !== res_t'(j + 5)) begin
        bad++; $display("FAIL midreset_y%0d got=%0d want=%0d", j, data_out, j + 5);
      end
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL midreset_extra_done got=%0d want=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    fork
      begin
        pulse_start();
        for (int p = 0; p < 1000; p++) begin
          for (int i = 0; i < 16; i++) a_m[i] = word_t'(-int'($urandom_range(90, 0)));
          for (int k = 0; k < 4; k++) x_v[k] = word_t'(-int'($urandom_range(90, 0)));
          send_words(p != 999);
        end
        @(negedge clk); start = 1'b0; data_in = 8'sd0;
      end
      begin
        int   last_cyc;
        int   n;
        res_t e;
        last_cyc = -1;
        for (int p = 0; p < 1000; p++) begin
          n = 0;
          while (n < 60 && done !== 1'b1) begin
            @(negedge clk); n++;
          end
          if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL b2b_done_timeout problem=%0d got=none want=pulse", p);
            break;
          end
          if (p > 0) begin
            total++;
            if (cyc - last_cyc !== 20) begin
              bad++; $display("FAIL b2b_spacing problem=%0d got=%0d want=20", p, cyc - last_cyc);
            end
          end
          last_cyc = cyc;
          for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'sd0;
            total++;
            if (data_out !== e || done !== 1'b0) begin
              bad++;
              $display("FAIL b2b_y problem=%0d idx=%0d got=%0d/%b want=%0d/0", p, j, data_out, done, e);
            end
          end
        end
      end
    join
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra !== 0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL b2b_tail extra_done=%0d left=%0d want 0/0", extra, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_reset_mid_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
